// File: rtl/matrix_add_pkg.sv
// Shared types and defaults for the matrix-add row scheduler.
package matrix_add_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int ROWS_DEF        = 11;
  localparam int ADD_LATENCY_DEF = 1;
endpackage

// File: rtl/matrix_add_scheduler_row_counter.sv
// row_counter: enable-gated up counter with synchronous clear and a terminal-value flag.
module row_counter
  import matrix_add_pkg::*;
#(
  parameter int W    = 4,
  parameter int TERM = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_term
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_count <= '0;
      end else if (i_inc) begin
        r_count <= r_count + W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == W'(TERM));
endmodule

// File: rtl/matrix_add_scheduler.sv
// Streams ROWS operand rows through a shared vector adder and writes the results back.
// Optional build macro MATRIX_ADD_SCHED_PERF_EN adds the cycleCount busy-cycle counter.
module matrix_add_scheduler
  import matrix_add_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              vecInReady,
  input  logic              vecOutReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              busy,
  output logic              done,
  output logic              errOverrun
`ifdef MATRIX_ADD_SCHED_PERF_EN
  ,
  output logic [15:0]       cycleCount
`endif
);
  // Outstanding results can never exceed the rows in flight or the adder depth.
  localparam int OUT_MAX = (ROWS > ADD_LATENCY) ? ROWS : ADD_LATENCY;
  localparam int OUT_W   = $clog2(OUT_MAX + 2);

  state_t           r_state;
  logic             r_vin;
  logic             r_err;
  logic [OUT_W-1:0] r_outs;

  logic              w_start_acc;
  logic              w_issue;
  logic              w_out_pend;
  logic              w_rd_term;
  logic              w_wr_term;
  logic [ADDR_W-1:0] w_rd_cnt;
  logic [ADDR_W-1:0] w_wr_cnt;

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign w_issue     = (r_state == S_ISSUE);
  assign w_start_acc = enable & start & (r_state == S_IDLE);
  assign w_out_pend  = (r_outs != '0);
  assign rdEn        = w_issue & enable;
  assign wrEn        = enable & busy & vecOutReady & w_out_pend;
  assign vecInReady  = r_vin;
  assign errOverrun  = r_err;
  assign rdAddr      = w_rd_cnt;
  assign wrAddr      = w_wr_cnt;

  row_counter #(.W(ADDR_W), .TERM(ROWS - 1)) u_rd_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_en    (enable),
    .i_clr   (w_start_acc),
    .i_inc   (rdEn),
    .o_count (w_rd_cnt),
    .o_term  (w_rd_term)
  );

  row_counter #(.W(ADDR_W), .TERM(ROWS - 1)) u_wr_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_en    (enable),
    .i_clr   (w_start_acc),
    .i_inc   (wrEn),
    .o_count (w_wr_cnt),
    .o_term  (w_wr_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (enable) begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_ISSUE;
        S_ISSUE: if (w_rd_term) r_state <= S_DRAIN;
        // Leave on the write that brings the write counter up to ROWS.
        S_DRAIN: if (wrEn && w_wr_term) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vin  <= 1'b0;
      r_outs <= '0;
      r_err  <= 1'b0;
    end else if (enable) begin
      r_vin <= w_issue;
      if (w_start_acc) begin
        r_outs <= '0;
        r_err  <= 1'b0;
      end else begin
        if (busy && vecOutReady && !w_out_pend) r_err <= 1'b1;
        case ({r_vin, wrEn})
          2'b10:   r_outs <= r_outs + OUT_W'(1);
          2'b01:   r_outs <= r_outs - OUT_W'(1);
          default: r_outs <= r_outs;
        endcase
      end
    end
  end

`ifdef MATRIX_ADD_SCHED_PERF_EN
  logic [15:0] r_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (enable) begin
      if (w_start_acc) begin
        r_cycles <= '0;
      end else if (busy && (r_cycles != 16'hFFFF)) begin
        r_cycles <= r_cycles + 16'd1;
      end
    end
  end

  assign cycleCount = r_cycles;
`endif
endmodule

// File: tb/tb_matrix_add_scheduler.sv
// Bench for matrix_add_scheduler: count-based reference model plus directed pass scenarios.
module tb_matrix_add_scheduler;
  localparam int ROWS = 11;
  localparam int L    = 1;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic          vecOutReady;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic          vecInReady;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic          busy;
  logic          done;
  logic          errOverrun;
`ifdef MATRIX_ADD_SCHED_PERF_EN
  logic [15:0]   cycleCount;
`endif

  always #5 clk = ~clk;

  matrix_add_scheduler #(.ROWS(ROWS), .ADD_LATENCY(L), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .rdEn        (rdEn),
    .rdAddr      (rdAddr),
    .vecInReady  (vecInReady),
    .vecOutReady (vecOutReady),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .busy        (busy),
    .done        (done),
    .errOverrun  (errOverrun)
`ifdef MATRIX_ADD_SCHED_PERF_EN
    ,
    .cycleCount  (cycleCount)
`endif
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a pass is described by enabled cycles since start,
  // results written so far and results still inside the adder.
  bit m_busy  = 1'b0;
  bit m_donef = 1'b0;
  bit m_err   = 1'b0;
  int m_t      = 0;
  int m_writes = 0;
  int m_outs   = 0;

  always @(negedge clk) begin
    bit e_vin, e_rd, e_wr;
    if (reset) begin
      chk("rst_rdEn", rdEn, 0);
      chk("rst_vin", vecInReady, 0);
      chk("rst_wrEn", wrEn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", errOverrun, 0);
      chk("rst_rdAddr", rdAddr, 0);
      chk("rst_wrAddr", wrAddr, 0);
      m_busy = 0; m_donef = 0; m_err = 0; m_t = 0; m_writes = 0; m_outs = 0;
    end else begin
      e_vin = m_busy && (m_t >= 1) && (m_t <= ROWS);
      e_rd  = enable && m_busy && (m_t < ROWS);
      e_wr  = enable && m_busy && vecOutReady && (m_outs > 0);
      chk("rdEn", rdEn, e_rd);
      chk("vecInReady", vecInReady, e_vin);
      chk("wrEn", wrEn, e_wr);
      chk("busy", busy, m_busy);
      chk("done", done, m_busy && m_donef);
      chk("errOverrun", errOverrun, m_err);
      if (e_rd) chk("rdAddr", rdAddr, m_t);
      if (e_wr) chk("wrAddr", wrAddr, m_writes);
      if (enable) begin
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_t = 0; m_writes = 0; m_outs = 0; m_err = 0; m_donef = 0;
          end
        end else begin
          if (vecOutReady && m_outs == 0) m_err = 1;
          m_outs = m_outs + (e_vin ? 1 : 0) - (e_wr ? 1 : 0);
          if (e_wr) m_writes++;
          if (m_donef) begin
            m_busy = 0; m_donef = 0;
          end else if (m_writes == ROWS) begin
            m_donef = 1;
          end
          m_t++;
        end
      end
    end
  end

  // Adder stand-in and per-scenario observations.
  bit adder_out = 1'b0;
  bit pipe[$];
  int cycle;
  int n_rd, first_rd, last_rd, first_rdaddr, rd_after_done;
  int n_wr, first_wr, last_wr;
  int n_done, first_done, last_done;
  int cc_at_done;

  task automatic clear_obs();
    cycle = 0;
    n_rd = 0; first_rd = -1; last_rd = -1; first_rdaddr = -1; rd_after_done = -1;
    n_wr = 0; first_wr = -1; last_wr = -1;
    n_done = 0; first_done = -1; last_done = -1; cc_at_done = -1;
  endtask

  task automatic cyc(input bit en, input bit st, input bit fo);
    bit vin_s, rst_s;
    enable = en;
    start = st;
    vecOutReady = adder_out | fo;
    @(negedge clk);
    vin_s = vecInReady;
    rst_s = reset;
    if (rdEn) begin
      if (first_rd < 0) begin first_rd = cycle; first_rdaddr = int'(rdAddr); end
      if (n_done > 0 && rd_after_done < 0) rd_after_done = cycle;
      last_rd = cycle; n_rd++;
    end
    if (wrEn) begin
      if (first_wr < 0) first_wr = cycle;
      last_wr = cycle; n_wr++;
    end
    if (done) begin
      if (first_done < 0) first_done = cycle;
`ifdef MATRIX_ADD_SCHED_PERF_EN
      if (n_done == 0) cc_at_done = int'(cycleCount);
`endif
      last_done = cycle; n_done++;
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      pipe.delete();
      repeat (L - 1) pipe.push_back(1'b0);
      adder_out = 1'b0;
    end else if (en) begin
      pipe.push_back(vin_s);
      adder_out = pipe.pop_front();
    end
    cycle++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; vecOutReady = 1'b0;
    repeat (L - 1) pipe.push_back(1'b0);
    clear_obs();
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("init_busy", busy, 0);
    chk("init_rdAddr", rdAddr, 0);
    chk("init_err", errOverrun, 0);
    reset = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);

    // Nominal pass
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    repeat (17) cyc(1'b1, 1'b0, 1'b0);
    chk("nom_first_rd", first_rd, 1);
    chk("nom_last_rd", last_rd, 11);
    chk("nom_n_rd", n_rd, 11);
    chk("nom_first_wr", first_wr, 3);
    chk("nom_last_wr", last_wr, 13);
    chk("nom_n_wr", n_wr, 11);
    chk("nom_n_done", n_done, 1);
    chk("nom_done_cycle", first_done, 14);
`ifdef MATRIX_ADD_SCHED_PERF_EN
    chk("nom_cycleCount", cc_at_done, 13);
`endif

    // Stall: enable low in cycles 5..7
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 24; c++) cyc(!(c >= 5 && c <= 7), 1'b0, 1'b0);
    chk("stall_n_wr", n_wr, 11);
    chk("stall_n_rd", n_rd, 11);
    chk("stall_last_rd", last_rd, 14);
    chk("stall_done_cycle", first_done, 17);

    // Back-to-back with start held high
    clear_obs();
    for (int c = 0; c <= 29; c++) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("b2b_n_done", n_done, 2);
    chk("b2b_first_done", first_done, 14);
    chk("b2b_last_done", last_done, 29);
    chk("b2b_second_rd", rd_after_done, 16);
    chk("b2b_n_rd", n_rd, 22);

    // Stray adder result while idle
    clear_obs();
    cyc(1'b1, 1'b0, 1'b1);
    chk("idle_stray_wr", n_wr, 0);
    chk("idle_stray_err", errOverrun, 0);

    // Extra adder result once every row has been written
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    repeat (13) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("ovr_n_wr", n_wr, 11);
    chk("ovr_err_sticky", errOverrun, 1);
    chk("ovr_idle", busy, 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ovr_err_cleared", errOverrun, 0);
    repeat (16) cyc(1'b1, 1'b0, 1'b0);

    // Reset in the middle of issuing
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rdEn", rdEn, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vin", vecInReady, 0);
    chk("mid_rst_rdAddr", rdAddr, 0);
    cyc(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    repeat (16) cyc(1'b1, 1'b0, 1'b0);
    chk("restart_first_rdaddr", first_rdaddr, 0);
    chk("restart_first_rd", first_rd, 1);
    chk("restart_n_wr", n_wr, 11);
    chk("restart_done_cycle", first_done, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
